// File: rtl/bus_pkg.sv
// Shared definitions for the single-master bus fabric: size codes, FSM states,
// slave count and the address-match helper.
package bus_pkg;

  localparam int NSLV = 3;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  localparam logic [31:0] ERR_DATA_DFLT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } bus_state_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bus_decoder_1x3_if.sv
// Single-master request/response bus. The master drives the request and
// receives ack/err/read data; the slave side mirrors it.
interface bus_decoder_1x3_if;
  logic        bus_en;
  logic        wr_rd;
  logic [31:0] wr_data;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        ack;
  logic        err;
  logic [31:0] rd_data;

  // Downstream slaves have no error line, so err is absent from the master view.
  modport master (output bus_en, wr_rd, wr_data, addr, size,
                  input  ack, rd_data);
  modport slave  (input  bus_en, wr_rd, wr_data, addr, size,
                  output ack, err, rd_data);
endinterface

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter: counts enabled cycles and flags the last permitted one.
// Shared with the arbiter's starvation guard.
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + 16'd1;
  end

  assign o_expire = i_en && (cnt == LAST);

endmodule

// File: rtl/bus_decoder_1x3.sv
// 1-master to 3-slave address decoder with response mux, miss error and
// slave timeout. Each request is latched; the selected slave sees it one cycle later.
module bus_decoder_1x3
  import bus_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE  = 32'h1000_0000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_F000,
  parameter logic [31:0] S2_BASE  = 32'h2000_0000,
  parameter logic [31:0] S2_MASK  = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DFLT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bus_decoder_1x3_if.slave  m,
  bus_decoder_1x3_if.master s0,
  bus_decoder_1x3_if.master s1,
  bus_decoder_1x3_if.master s2
);

  bus_state_t      state;
  logic [NSLV-1:0] sel;
  logic [NSLV-1:0] hit_sel;
  logic [NSLV-1:0] ack_v;
  logic [31:0]     rd_v [NSLV];
  logic [31:0]     rd_sel;
  logic            sel_ack;
  logic            expire;
  logic            wr_rd_q;
  logic [31:0]     wr_data_q;
  logic [31:0]     addr_q;
  logic [2:0]      size_q;

  assign ack_v   = {s2.ack, s1.ack, s0.ack};
  assign rd_v[0] = s0.rd_data;
  assign rd_v[1] = s1.rd_data;
  assign rd_v[2] = s2.rd_data;

  // Fixed priority S0 > S1 > S2 when windows overlap.
  always_comb begin
    hit_sel = '0;
    if (addr_hit(m.addr, S0_BASE, S0_MASK))      hit_sel = 3'b001;
    else if (addr_hit(m.addr, S1_BASE, S1_MASK)) hit_sel = 3'b010;
    else if (addr_hit(m.addr, S2_BASE, S2_MASK)) hit_sel = 3'b100;
  end

  // sel is non-zero only in WAIT, so stray acks outside WAIT are masked here.
  assign sel_ack = |(ack_v & sel);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NSLV; i++)
      if (sel[i]) rd_sel = rd_v[i];
  end

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    ((state != WAIT) || sel_ack),
    .i_en     ((state == WAIT) && !sel_ack),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      sel       <= '0;
      wr_rd_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= '0;
      size_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m.bus_en) begin
            if (|hit_sel) begin
              sel       <= hit_sel;
              wr_rd_q   <= m.wr_rd;
              wr_data_q <= m.wr_data;
              addr_q    <= m.addr;
              size_q    <= m.size;
              state     <= WAIT;
            end else begin
              state <= ERR;
            end
          end
        end
        WAIT: begin
          // A slave ack in the final permitted cycle still wins over the timeout.
          if (sel_ack) begin
            sel   <= '0;
            state <= IDLE;
          end else if (expire) begin
            sel   <= '0;
            state <= ERR;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m.ack     = (state == ERR) || sel_ack;
  assign m.err     = (state == ERR);
  assign m.rd_data = (state == ERR) ? ERR_DATA : (sel_ack ? rd_sel : '0);

  assign s0.bus_en  = sel[0];
  assign s0.wr_rd   = sel[0] & wr_rd_q;
  assign s0.wr_data = sel[0] ? wr_data_q : '0;
  assign s0.addr    = sel[0] ? addr_q    : '0;
  assign s0.size    = sel[0] ? size_q    : '0;

  assign s1.bus_en  = sel[1];
  assign s1.wr_rd   = sel[1] & wr_rd_q;
  assign s1.wr_data = sel[1] ? wr_data_q : '0;
  assign s1.addr    = sel[1] ? addr_q    : '0;
  assign s1.size    = sel[1] ? size_q    : '0;

  assign s2.bus_en  = sel[2];
  assign s2.wr_rd   = sel[2] & wr_rd_q;
  assign s2.wr_data = sel[2] ? wr_data_q : '0;
  assign s2.addr    = sel[2] ? addr_q    : '0;
  assign s2.size    = sel[2] ? size_q    : '0;

endmodule

// File: tb/tb_bus_decoder_1x3.sv
// Randomized bench for bus_decoder_1x3 against a cycle-level transaction model.
module tb_bus_decoder_1x3;
  import bus_pkg::*;

  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  bus_decoder_1x3_if m ();
  bus_decoder_1x3_if s0 ();
  bus_decoder_1x3_if s1 ();
  bus_decoder_1x3_if s2 ();

  assign s0.err = 1'b0;
  assign s1.err = 1'b0;
  assign s2.err = 1'b0;

  bus_decoder_1x3 #(.TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .m     (m.slave),
    .s0    (s0.master),
    .s1    (s1.master),
    .s2    (s2.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address map as stated: masked compare, lowest slave index wins.
  function automatic int ref_slave(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
    if ((a & 32'hFFFF_F000) == 32'h1000_0000) return 1;
    if ((a & 32'hFFFF_F000) == 32'h2000_0000) return 2;
    return -1;
  endfunction

  function automatic logic get_en(input int j);
    case (j)
      0: return s0.bus_en;
      1: return s1.bus_en;
      default: return s2.bus_en;
    endcase
  endfunction

  function automatic logic [68:0] get_req(input int j);
    case (j)
      0: return {s0.wr_rd, s0.wr_data, s0.addr, s0.size, s0.bus_en};
      1: return {s1.wr_rd, s1.wr_data, s1.addr, s1.size, s1.bus_en};
      default: return {s2.wr_rd, s2.wr_data, s2.addr, s2.size, s2.bus_en};
    endcase
  endfunction

  task automatic set_slv(input int j, input logic a, input logic [31:0] d);
    case (j)
      0: begin s0.ack = a; s0.rd_data = d; end
      1: begin s1.ack = a; s1.rd_data = d; end
      default: begin s2.ack = a; s2.rd_data = d; end
    endcase
  endtask

  task automatic clear_slaves();
    for (int j = 0; j < 3; j++) set_slv(j, 1'b0, $urandom);
  endtask

  // One master transaction. lat = wait cycles before the slave acks
  // (lat >= TMO means the slave never acks in time). noise scrambles the
  // master request after it is accepted and injects acks from other slaves.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [2:0] size, input int lat, input logic [31:0] rdata,
                         input bit noise);
    int k;
    int done_c;
    bit tmo;
    logic [31:0] exp_rd;
    logic [68:0] req;
    k      = ref_slave(addr);
    tmo    = (k >= 0) && (lat >= TMO);
    done_c = (k < 0) ? 1 : (tmo ? TMO + 1 : lat + 1);
    exp_rd = (k < 0 || tmo) ? 32'h0 : rdata;
    @(negedge clk);
    clear_slaves();
    m.bus_en = 1'b1; m.wr_rd = wr; m.wr_data = wdata; m.addr = addr; m.size = size;
    #1;
    check("req_cycle_ack", {31'd0, m.ack}, 32'd0);
    for (int j = 0; j < 3; j++) check("req_cycle_en", {31'd0, get_en(j)}, 32'd0);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      clear_slaves();
      if (noise) begin
        int j;
        m.addr = $urandom; m.wr_data = $urandom; m.wr_rd = ~wr; m.bus_en = 1'($urandom);
        j = (k < 0) ? int'($urandom_range(2, 0)) : (k + 1 + int'($urandom_range(1, 0))) % 3;
        set_slv(j, 1'($urandom), $urandom);
      end
      if (k >= 0 && !tmo && c == done_c) set_slv(k, 1'b1, rdata);
      #1;
      for (int j = 0; j < 3; j++)
        check($sformatf("en_s%0d_c%0d", j, c), {31'd0, get_en(j)},
              {31'd0, (j == k) && (c < done_c || (!tmo && c == done_c))});
      check($sformatf("ack_c%0d", c), {31'd0, m.ack}, {31'd0, c == done_c});
      if (c == done_c) begin
        check("err", {31'd0, m.err}, {31'd0, (k < 0) || tmo});
        check("rd_data", m.rd_data, exp_rd);
      end
      if (k >= 0 && c == 1) begin
        for (int j = 0; j < 3; j++) begin
          req = get_req(j);
          if (j == k) begin
            check("slv_wr_rd", {31'd0, req[68]}, {31'd0, wr});
            check("slv_wr_data", req[67:36], wdata);
            check("slv_addr", req[35:4], addr);
            check("slv_size", {29'd0, req[3:1]}, {29'd0, size});
          end else begin
            check("unsel_fields", req[68:36] | {1'b0, req[35:4]} | {30'd0, req[3:1]}, 32'd0);
          end
        end
      end
    end
    m.bus_en = 1'b0;
  endtask

  task automatic run_reset_mid_wait();
    @(negedge clk);
    clear_slaves();
    m.bus_en = 1'b1; m.wr_rd = 1'b0; m.addr = 32'h0000_0040; m.size = SZ_WORD;
    @(negedge clk);
    #1 check("rst_pre_en", {31'd0, s0.bus_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_ack", {31'd0, m.ack}, 32'd0);
    check("rst_err", {31'd0, m.err}, 32'd0);
    check("rst_rd", m.rd_data, 32'd0);
    check("rst_en", {29'd0, s2.bus_en, s1.bus_en, s0.bus_en}, 32'd0);
    check("rst_addr", s0.addr, 32'd0);
    set_slv(0, 1'b1, 32'hA5A5_A5A5);
    #1 check("rst_ack_late", {31'd0, m.ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m.bus_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_ack", {31'd0, m.ack}, 32'd0);
      check("post_rst_en", {31'd0, s0.bus_en}, 32'd0);
    end
    clear_slaves();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    m.bus_en = 1'b0; m.wr_rd = 1'b0; m.wr_data = '0; m.addr = '0; m.size = '0;
    clear_slaves();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_ack", {31'd0, m.ack}, 32'd0);
    check("reset_err", {31'd0, m.err}, 32'd0);
    check("reset_rd", m.rd_data, 32'd0);
    check("reset_en", {29'd0, s2.bus_en, s1.bus_en, s0.bus_en}, 32'd0);
    check("reset_fields", s0.addr | s1.wr_data | {29'd0, s2.size}, 32'd0);
    rst = 1'b0;

    run_txn(32'h0000_0010, 1'b0, 32'h0, SZ_WORD, 0, 32'hCAFE_F00D, 1'b0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, SZ_WORD, 1, 32'hCAFE_F00D, 1'b0);
    run_txn(32'h1000_0004, 1'b1, 32'h1234_5678, SZ_WORD, 1, 32'h0, 1'b0);
    run_txn(32'h3000_0000, 1'b0, 32'h0, SZ_WORD, 0, 32'h0, 1'b0);
    run_txn(32'h2000_0000, 1'b0, 32'h0, SZ_BYTE, 100, 32'h0, 1'b0);
    run_txn(32'h0000_0020, 1'b0, 32'h0, SZ_HALF, TMO - 1, 32'h7777_1111, 1'b0);
    run_txn(32'h0000_0100, 1'b1, 32'hDEAD_0001, SZ_WORD, 2, 32'h1111_2222, 1'b1);
    run_txn(32'h0000_0104, 1'b0, 32'h0, SZ_WORD, 0, 32'h3333_4444, 1'b1);
    run_txn(32'h0000_FFFF, 1'b0, 32'h0, SZ_BYTE, 0, 32'h0BAD_F00D, 1'b0);
    run_txn(32'h0001_0000, 1'b0, 32'h0, SZ_BYTE, 0, 32'h0, 1'b0);
    run_txn(32'h1000_0FFF, 1'b1, 32'h55AA_55AA, SZ_BYTE, 0, 32'h0, 1'b0);
    run_txn(32'h1000_1000, 1'b0, 32'h0, SZ_BYTE, 0, 32'h0, 1'b0);
    run_txn(32'h2000_0FFF, 1'b0, 32'h0, SZ_HALF, 3, 32'h9999_8888, 1'b1);
    run_reset_mid_wait();

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      case ($urandom_range(3, 0))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {20'h10000, 12'($urandom)};
        2:       a = {20'h20000, 12'($urandom)};
        default: a = $urandom;
      endcase
      run_txn(a, 1'($urandom), $urandom, 3'($urandom_range(2, 0)),
              int'($urandom_range(TMO + 1, 0)), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
